// File: rtl/led_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_mode_ctrl
// Brief    : One-hot 4-LED sequencer. A short press steps the LED one place;
//            a long press toggles AUTO mode, which steps it on a tick period.
// Revision : 1.0 - initial release
// ============================================================================
module led_mode_ctrl #(
  parameter int TICK_DIV   = 1000,
  parameter int CNT_W      = 8,
  parameter int LONG_TICKS = 8,
  parameter int AUTO_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       but_deb,
  output logic [3:0] led_o,
  output logic       auto_o,
  output logic       step_o
);

  localparam int               PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] AUTO_LAST  = CNT_W'(AUTO_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] auto_cnt;
  logic             but_1d;

  logic tick;
  logic rise;
  logic fall;
  logic short_press;
  logic long_press;
  logic hold_clr;
  logic hold_inc;
  logic auto_run;
  logic auto_exp;
  logic step_req;

  assign tick = (presc == PRESC_LAST);
  assign rise = but_deb & ~but_1d;
  assign fall = ~but_deb & but_1d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A release always beats a long-qualifying tick arriving in the same cycle.
  always_comb begin
    state_nxt   = state;
    short_press = 1'b0;
    long_press  = 1'b0;
    hold_clr    = 1'b0;
    hold_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESS;
          hold_clr  = 1'b1;
        end
      end
      PRESS: begin
        if (fall) begin
          short_press = 1'b1;
          state_nxt   = IDLE;
        end else if (tick) begin
          hold_inc = 1'b1;
          if (hold_cnt == LONG_LAST) begin
            long_press = 1'b1;
            state_nxt  = HELD;
          end
        end
      end
      HELD: begin
        if (fall) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // AUTO ticks only accumulate while the button is untouched.
  assign auto_run = auto_o & (state == IDLE) & tick;
  assign auto_exp = auto_run & (auto_cnt == AUTO_LAST);
  assign step_req = short_press | auto_exp;

  always_ff @(posedge clk) begin
    if (rst) begin
      but_1d   <= 1'b0;
      presc    <= '0;
      hold_cnt <= '0;
      auto_cnt <= '0;
      led_o    <= 4'b0001;
      auto_o   <= 1'b0;
      step_o   <= 1'b0;
    end else begin
      but_1d <= but_deb;
      step_o <= step_req;

      if (tick) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end

      if (hold_clr) begin
        hold_cnt <= '0;
      end else if (hold_inc) begin
        hold_cnt <= hold_cnt + 1'b1;
      end

      if (long_press || step_req) begin
        auto_cnt <= '0;
      end else if (auto_run) begin
        auto_cnt <= auto_cnt + 1'b1;
      end

      if (long_press) begin
        auto_o <= ~auto_o;
      end

      if (step_req) begin
        led_o <= {led_o[2:0], led_o[3]};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_mode_ctrl
// Brief    : Self-checking bench for led_mode_ctrl against a press-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_mode_ctrl;

  localparam int TICK_DIV   = 1;
  localparam int CNT_W      = 8;
  localparam int LONG_TICKS = 4;
  localparam int AUTO_TICKS = 3;

  logic       clk;
  logic       rst;
  logic       but_deb;
  logic [3:0] led_o;
  logic       auto_o;
  logic       step_o;

  led_mode_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .CNT_W     (CNT_W),
    .LONG_TICKS(LONG_TICKS),
    .AUTO_TICKS(AUTO_TICKS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .but_deb(but_deb),
    .led_o  (led_o),
    .auto_o (auto_o),
    .step_o (step_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  // Press-level model: LED position as an integer, presses tracked by how many
  // ticks they have been held and whether they already qualified as long.
  int m_pos;
  bit m_auto;
  bit m_step;
  bit m_prev;
  bit m_in_press;
  bit m_long;
  int m_held;
  int m_auto_ticks;
  int m_presc;

  task automatic model_cycle(input bit b, input bit r);
    bit rise_e, fall_e, tick_e, was_idle, short_e, toggled, step_e;
    if (r) begin
      m_pos = 0; m_auto = 0; m_step = 0; m_prev = 0; m_in_press = 0;
      m_long = 0; m_held = 0; m_auto_ticks = 0; m_presc = 0;
      return;
    end
    rise_e  = b && !m_prev;
    fall_e  = !b && m_prev;
    m_prev  = b;
    tick_e  = (m_presc == TICK_DIV - 1);
    m_presc = tick_e ? 0 : m_presc + 1;
    was_idle = !m_in_press;
    short_e = 0; toggled = 0; step_e = 0;
    if (!m_in_press) begin
      if (rise_e) begin
        m_in_press = 1; m_held = 0; m_long = 0;
      end
    end else if (!m_long) begin
      if (fall_e) begin
        m_in_press = 0; short_e = 1;
      end else if (tick_e) begin
        m_held++;
        if (m_held == LONG_TICKS) begin
          m_auto = !m_auto; m_long = 1; toggled = 1;
        end
      end
    end else if (fall_e) begin
      m_in_press = 0;
    end
    step_e = short_e;
    if (toggled || short_e) begin
      m_auto_ticks = 0;
    end else if (m_auto && was_idle && tick_e) begin
      m_auto_ticks++;
      if (m_auto_ticks == AUTO_TICKS) begin
        m_auto_ticks = 0; step_e = 1;
      end
    end
    if (step_e) m_pos = (m_pos + 1) % 4;
    m_step = step_e;
  endtask

  task automatic run(input bit b, input bit r, input int n);
    for (int i = 0; i < n; i++) begin
      but_deb = b;
      rst     = r;
      @(posedge clk);
      model_cycle(b, r);
      #1;
      check("led_o",  led_o, 4'(1 << m_pos));
      check("auto_o", {3'b0, auto_o}, {3'b0, m_auto});
      check("step_o", {3'b0, step_o}, {3'b0, m_step});
    end
  endtask

  initial begin
    but_deb = 1'b0;
    rst     = 1'b1;
    #2;
    // Reset with button released.
    run(0, 1, 3);
    // Four short presses.
    for (int k = 0; k < 4; k++) begin
      run(1, 0, 2);
      run(0, 0, 2);
    end
    // Long press enters AUTO without stepping.
    run(1, 0, 10);
    run(0, 0, 1);
    // AUTO idle stepping, then pause while held.
    run(0, 0, 9);
    run(1, 0, 6);
    run(0, 0, 5);
    // Short press while in AUTO.
    run(1, 0, 2);
    run(0, 0, 6);
    // Reset while held long, releasing the button during reset.
    run(1, 0, 8);
    run(1, 1, 2);
    run(0, 1, 1);
    run(0, 0, 4);
    // Reset released with the button still down counts as a press.
    run(1, 1, 2);
    run(1, 0, 2);
    run(0, 0, 3);
    // Randomized presses, gaps and occasional resets.
    for (int k = 0; k < 150; k++) begin
      run(0, 0, $urandom_range(0, 6));
      run(1, 0, $urandom_range(1, 9));
      if ($urandom_range(0, 14) == 0) begin
        run($urandom_range(0, 1) == 1, 1, $urandom_range(1, 2));
      end
    end
    run(0, 0, 8);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
